md5_job_ctrl: RTL and testbench



---
 rtl/md5_pkg.sv | 15 +
 rtl/md5_host_regs.sv | 44 ++++
 rtl/md5_job_ctrl.sv | 103 ++++++++++
 tb/tb_md5_job_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// md5_pkg: shared host address map, CTRL/STATUS bit indices and job FSM states
package md5_pkg;
  localparam logic [5:0] ADDR_START  = 6'h00;
  localparam logic [5:0] ADDR_HASH   = 6'h10;
  localparam logic [5:0] ADDR_CTRL   = 6'h14;
  localparam logic [5:0] ADDR_STATUS = 6'h15;
  localparam logic [5:0] ADDR_CYCLES = 6'h16;
  localparam logic [5:0] ADDR_RESULT = 6'h20;
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int ST_BUSY    = 0;
  localparam int ST_FOUND   = 1;
  localparam int ST_EXH     = 2;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
endpackage

// File: rtl/md5_host_regs.sv
// md5_host_regs: start/hash/result register file with registered read mux (host wr/rd, lock, result clr/cap, status/cycles in)
module md5_host_regs import md5_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [5:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         lock,
  input  logic         clr,
  input  logic         cap,
  input  logic [511:0] result_str,
  input  logic [2:0]   status,
  input  logic [31:0]  cycles,
  input  logic [5:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic [511:0] start_str,
  output logic [127:0] hash
);
  logic [511:0] result;
  logic [31:0]  rd_next;
  logic         wr_ok;
  always_comb begin
    wr_ok   = wr_en && !lock;
    rd_next = rd_addr[5:4] == ADDR_START[5:4]  ? start_str[{rd_addr[3:0], 5'd0} +: 32] :
              rd_addr[5:4] == ADDR_RESULT[5:4] ? result[{rd_addr[3:0], 5'd0} +: 32] :
              rd_addr[5:2] == ADDR_HASH[5:2]   ? hash[{rd_addr[1:0], 5'd0} +: 32] :
              rd_addr == ADDR_STATUS           ? {29'd0, status} :
              rd_addr == ADDR_CYCLES           ? cycles : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      start_str <= '0;
      hash      <= '0;
      result    <= '0;
      rd_data   <= '0;
    end else begin
      if (wr_ok && wr_addr[5:4] == ADDR_START[5:4]) start_str[{wr_addr[3:0], 5'd0} +: 32] <= wr_data;
      if (wr_ok && wr_addr[5:2] == ADDR_HASH[5:2]) hash[{wr_addr[1:0], 5'd0} +: 32] <= wr_data;
      if (clr) result <= '0;
      else if (cap) result <= result_str;
      rd_data <= rd_next;
    end
  end
endmodule

// File: rtl/md5_job_ctrl.sv
// md5_job_ctrl: host-controlled MD5 brute-force job FSM (host bus, irq, engine ce/resets, start block, target digest, match/exhaust inputs)
module md5_job_ctrl import md5_pkg::*; #(
  parameter int CLR_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [5:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic [5:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic         irq,
  output logic         bf_ce,
  output logic         bf_reset,
  output logic         bf_reset_zero_string,
  output logic [511:0] start_str,
  output logic [31:0]  a_MD5_hash,
  output logic [31:0]  b_MD5_hash,
  output logic [31:0]  c_MD5_hash,
  output logic [31:0]  d_MD5_hash,
  input  logic         find_str,
  input  logic [511:0] result_str,
  input  logic         symbols_done
);
  localparam int CW = $clog2(CLR_CYCLES + 1);
  state_t       state;
  logic [CW-1:0] cnt;
  logic         to_idle, found, exhausted, busy, ctrl_wr, start, abort;
  logic [2:0]   status;
  logic [31:0]  cycles;
  logic [127:0] hash;
  always_comb begin
    busy             = state == CLEAR || state == RUN;
    ctrl_wr          = wr_en && wr_addr == ADDR_CTRL;
    start            = ctrl_wr && wr_data[CTRL_START] && !busy;
    abort            = ctrl_wr && wr_data[CTRL_ABORT] && state == RUN;
    status           = '0;
    status[ST_BUSY]  = busy;
    status[ST_FOUND] = found;
    status[ST_EXH]   = exhausted;
  end
  assign {d_MD5_hash, c_MD5_hash, b_MD5_hash, a_MD5_hash} = hash;
  md5_host_regs u_regs (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock(busy), .clr(start), .cap(state == RUN && find_str && !abort),
    .result_str(result_str), .status(status), .cycles(cycles),
    .rd_addr(rd_addr), .rd_data(rd_data), .start_str(start_str), .hash(hash)
  );
  // cnt counts down the engine-reset hold; it is also loaded on reset so the
  // engine stays in reset for CLR_CYCLES cycles after release while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      cnt                  <= CW'(CLR_CYCLES);
      to_idle              <= 1'b0;
      found                <= 1'b0;
      exhausted            <= 1'b0;
      cycles               <= '0;
      irq                  <= 1'b0;
      bf_ce                <= 1'b0;
      bf_reset             <= 1'b1;
      bf_reset_zero_string <= 1'b1;
    end else begin
      irq                  <= 1'b0;
      if (cnt != '0) cnt <= cnt - 1'b1;
      bf_reset             <= cnt > CW'(1);
      bf_reset_zero_string <= cnt > CW'(1);
      unique case (state)
        IDLE, DONE: if (start) begin
          state                <= CLEAR;
          cnt                  <= CW'(CLR_CYCLES);
          bf_reset             <= 1'b1;
          bf_reset_zero_string <= 1'b1;
          to_idle              <= 1'b0;
          found                <= 1'b0;
          exhausted            <= 1'b0;
          cycles               <= '0;
        end
        CLEAR: if (cnt == CW'(1)) begin
          state <= to_idle ? IDLE : RUN;
          bf_ce <= !to_idle;
        end
        RUN: begin
          if (cycles != '1) cycles <= cycles + 1'b1;
          if (abort) begin
            state                <= CLEAR;
            cnt                  <= CW'(CLR_CYCLES);
            bf_reset             <= 1'b1;
            bf_reset_zero_string <= 1'b1;
            to_idle              <= 1'b1;
            bf_ce                <= 1'b0;
          end else if (find_str || symbols_done) begin
            state     <= DONE;
            found     <= find_str;
            exhausted <= !find_str;
            bf_ce     <= 1'b0;
            irq       <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_md5_job_ctrl.sv
// tb_md5_job_ctrl: randomized scoreboard bench for md5_job_ctrl against a register-level job model
module tb_md5_job_ctrl;
  logic clk = 0, reset = 1, wr_en = 0, find_str = 0, symbols_done = 0;
  logic [5:0] wr_addr = 0, rd_addr = 0;
  logic [31:0] wr_data = 0;
  logic [511:0] result_str = 0;
  logic [31:0] rd_data, a_MD5_hash, b_MD5_hash, c_MD5_hash, d_MD5_hash;
  logic irq, bf_ce, bf_reset, bf_reset_zero_string;
  logic [511:0] start_str;

  md5_job_ctrl dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .irq(irq), .bf_ce(bf_ce), .bf_reset(bf_reset),
    .bf_reset_zero_string(bf_reset_zero_string), .start_str(start_str),
    .a_MD5_hash(a_MD5_hash), .b_MD5_hash(b_MD5_hash), .c_MD5_hash(c_MD5_hash), .d_MD5_hash(d_MD5_hash),
    .find_str(find_str), .result_str(result_str), .symbols_done(symbols_done)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0, irq_cnt = 0;
  logic rd_req = 0, rd_vld = 0;
  logic [31:0] exp_q[$];
  string name_q[$];
  logic [31:0] sm[16], hm[4], rm[16], cym;
  logic busy_m, found_m, exh_m;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  function automatic void chkw(input string n, input logic [511:0] act, input logic [511:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  function automatic logic [511:0] sm_pack();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = sm[i];
    return r;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin sm[i] = 0; rm[i] = 0; end
    for (int i = 0; i < 4; i++) hm[i] = 0;
    cym = 0; busy_m = 0; found_m = 0; exh_m = 0;
  endfunction

  function automatic void host_model(input logic [5:0] a, input logic [31:0] d);
    if (!busy_m && a < 6'h10) sm[a[3:0]] = d;
    else if (!busy_m && a < 6'h14) hm[a[1:0]] = d;
    else if (a == 6'h14 && d[0] && !busy_m) begin
      busy_m = 1; found_m = 0; exh_m = 0; cym = 0;
      for (int i = 0; i < 16; i++) rm[i] = 0;
    end
  endfunction

  function automatic logic [31:0] mread(input logic [5:0] a);
    if (a < 6'h10) return sm[a[3:0]];
    if (a < 6'h14) return hm[a[1:0]];
    if (a == 6'h15) return {29'd0, exh_m, found_m, busy_m};
    if (a == 6'h16) return cym;
    if (a >= 6'h20 && a < 6'h30) return rm[a[3:0]];
    return 32'd0;
  endfunction

  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (irq) irq_cnt++;
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL rd_unexpected: got %0h with no expected entry", rd_data);
      end else chk(name_q.pop_front(), rd_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    host_model(a, d);
    tick();
    wr_en = 0;
  endtask

  task automatic rdm(input logic [5:0] a, input string n);
    rd_addr = a; rd_req = 1;
    exp_q.push_back(mread(a)); name_q.push_back(n);
    tick();
    rd_req = 0;
  endtask

  task automatic clr_chk(input int pre);
    int nr, nz;
    nr = pre; nz = pre;
    while ((bf_reset || bf_reset_zero_string) && nr + nz < 100) begin
      nr += int'(bf_reset); nz += int'(bf_reset_zero_string);
      tick();
    end
    chk("clr_len_bf_reset", nr, 4);
    chk("clr_len_zero_string", nz, 4);
  endtask

  task automatic check_ports();
    chkw("start_str_port", start_str, sm_pack());
    chk("hash_a_port", a_MD5_hash, hm[0]);
    chk("hash_b_port", b_MD5_hash, hm[1]);
    chk("hash_c_port", c_MD5_hash, hm[2]);
    chk("hash_d_port", d_MD5_hash, hm[3]);
  endtask

  task automatic read_all();
    rdm(6'h15, "status");
    rdm(6'h16, "cycles");
    for (int i = 0; i < 16; i++) rdm(6'(6'h20 + i), "result_word");
    for (int i = 0; i < 4; i++) rdm(6'(6'h10 + i), "hash_word");
    rdm(6'($urandom_range(0, 15)), "start_word");
    rdm(6'h14, "ctrl_reads_zero");
    rdm(6'h17, "unmapped_17");
    rdm(6'(6'h30 + $urandom_range(0, 15)), "unmapped_3x");
  endtask

  // kind: 0 found, 1 exhausted, 2 found+exhausted same cycle, 3 abort with same-cycle find
  task automatic run_job(input int kind, input int k);
    logic [511:0] x, y;
    int i0;
    for (int i = 0; i < 16; i++) begin x[32*i +: 32] = $urandom; y[32*i +: 32] = $urandom; end
    for (int i = 0; i < 20; i++) wr(6'(i), $urandom);
    wr(6'h14, 32'h1);
    clr_chk(0);
    chk("bf_ce_in_run", 32'(bf_ce), 1);
    i0 = irq_cnt;
    rdm(6'h15, "status_busy");
    wr(6'h10, $urandom);
    wr(6'h14, 32'h1);
    repeat (k - 4) tick();
    find_str = kind != 1;
    symbols_done = kind == 1 || kind == 2;
    result_str = x;
    if (kind == 3) begin wr_en = 1; wr_addr = 6'h14; wr_data = 32'h2; end
    tick();
    find_str = 0; symbols_done = 0; wr_en = 0;
    cym = k;
    if (kind == 3) begin
      chk("abort_bf_reset", 32'(bf_reset), 1);
      rdm(6'h15, "status_abort_busy");
      clr_chk(1);
    end else begin
      if (kind != 1) begin
        found_m = 1;
        for (int i = 0; i < 16; i++) rm[i] = x[32*i +: 32];
      end else exh_m = 1;
      repeat (2) tick();
      find_str = 1; symbols_done = 1; result_str = y;
      tick();
      find_str = 0; symbols_done = 0;
      tick();
    end
    busy_m = 0;
    chk("irq_pulse_count", 32'(irq_cnt - i0), (kind == 3) ? 0 : 1);
    chk("bf_ce_after_job", 32'(bf_ce), 0);
    read_all();
    check_ports();
  endtask

  task automatic reset_mid_run();
    int i0;
    for (int i = 0; i < 20; i++) wr(6'(i), $urandom);
    wr(6'h14, 32'h1);
    clr_chk(0);
    repeat (7) tick();
    reset = 1; find_str = 1; result_str = {16{32'hDEADBEEF}};
    tick(); tick();
    find_str = 0;
    model_clear();
    chk("rst_bf_reset", 32'(bf_reset), 1);
    chk("rst_bf_zero_string", 32'(bf_reset_zero_string), 1);
    chk("rst_bf_ce", 32'(bf_ce), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_rd_data", rd_data, 0);
    check_ports();
    i0 = irq_cnt;
    reset = 0;
    clr_chk(0);
    chk("rst_no_irq", 32'(irq_cnt - i0), 0);
    read_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (3) tick();
    chk("por_bf_reset", 32'(bf_reset), 1);
    chk("por_bf_ce", 32'(bf_ce), 0);
    chk("por_irq", 32'(irq), 0);
    chk("por_rd_data", rd_data, 0);
    check_ports();
    reset = 0;
    clr_chk(0);
    rdm(6'h15, "por_status");
    rdm(6'h16, "por_cycles");
    run_job(0, 100);
    run_job(1, 20);
    run_job(2, 15);
    run_job(3, 10);
    wr(6'h14, 32'h2);
    rdm(6'h15, "abort_in_idle_status");
    rd_addr = 6'h05; rd_req = 1;
    exp_q.push_back(mread(6'h05)); name_q.push_back("same_cycle_old_value");
    wr(6'h05, 32'hA5A5_0005);
    rd_req = 0;
    rdm(6'h05, "written_value");
    for (int j = 0; j < 6; j++) run_job(int'($urandom_range(0, 3)), int'($urandom_range(6, 40)));
    reset_mid_run();
    repeat (2) tick();
    chk("rd_queue_drain", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
